mp_operand_unpack: RTL and testbench
====================================

MP_OPERAND_UNPACK -- requirements
Module: mp_operand_unpack

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the element-count field.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port cfg_valid, input, 1: start request, sampled only in IDLE.
REQ-005 SHALL have port cfg_prec, input, 2: precision, encoded 00=INT8, 01=FP16, 10=FP32, 11=illegal.
REQ-006 SHALL have port cfg_count, input, CNT_W: number of elements to emit.
REQ-007 SHALL have port cfg_ready, output, 1: high exactly when in IDLE.
REQ-008 SHALL have port in_valid, input, 1: packed input word valid.
REQ-009 SHALL have port in_ready, output, 1: packed input word accepted when in_valid && in_ready.
REQ-010 SHALL have port in_data, input, 32: packed word holding 4 INT8, 2 FP16 or 1 FP32 elements.
REQ-011 SHALL have port out_valid, output, 1: element valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts when out_valid && out_ready.
REQ-013 SHALL have port out_data, output, 32: unpacked element.
REQ-014 SHALL have port out_prec, output, 2: precision tag of out_data, equal to the latched cfg_prec.
REQ-015 SHALL have port out_last, output, 1: high with the final element of a job.
REQ-016 SHALL have port done, output, 1: one-cycle pulse on job completion.
REQ-017 SHALL have port err, output, 1: one-cycle pulse on an illegal-precision start.

Function
REQ-018 SHALL implement states IDLE, FETCH (buffer empty, awaiting word) and EMIT (buffer holds word, emitting lanes).
REQ-019 IDLE with cfg_valid and legal cfg_prec and cfg_count>0 SHALL latch prec and count, clear lane index, and go to FETCH next cycle.
REQ-020 IDLE with cfg_valid and cfg_count==0 and legal prec SHALL pulse done next cycle, consume no words, and stay IDLE.
REQ-021 IDLE with cfg_valid and cfg_prec==11 SHALL pulse err next cycle, latch nothing, and stay IDLE; err takes priority over the count==0 check.
REQ-022 cfg_valid outside IDLE SHALL be ignored.
REQ-023 in_ready SHALL be high in FETCH, and in EMIT only when the current lane is the word's last lane, the element is not the job's last, and out_ready is high; in_ready SHALL be low in IDLE.
REQ-024 A word accepted in cycle N SHALL have its lane 0 on out_valid in cycle N+1; sustained throughput SHALL be one element per cycle with no bubbles across word boundaries.
REQ-025 Lanes SHALL be emitted least-significant first: INT8 bits [7:0],[15:8],[23:16],[31:24]; FP16 bits [15:0],[31:16]; FP32 bits [31:0].
REQ-026 INT8 elements SHALL be sign-extended to 32 bits, FP16 elements zero-extended, and FP32 elements passed unchanged.
REQ-027 out_valid SHALL be high only in EMIT; out_data, out_prec and out_last SHALL hold stable while out_valid && !out_ready.
REQ-028 Each handshake SHALL decrement the remaining count; out_last SHALL be high when the remaining count is 1.
REQ-029 The handshake on the last element SHALL return to IDLE, discard the unused lanes of the final word, and pulse done in the following cycle.
REQ-030 On a handshake at the word's last lane with no simultaneous input accept, the block SHALL go to FETCH.
REQ-031 The remaining-count register SHALL never wrap below zero.

Reset
REQ-032 While rst is high, the block SHALL enter IDLE, clear the buffer, lane index and count, and drive out_valid=0, in_ready=0, cfg_ready=0, done=0, err=0, out_last=0, out_data=0 and out_prec=00.
REQ-033 cfg_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-034 rst asserted mid-job SHALL abort the job without asserting done, and any partially emitted word SHALL be lost.

Verification
REQ-035 INT8, count=6, words 0x80FF7F01 then 0x0000_0302, out_ready=1 -> out_data 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80, 0x00000002, 0x00000003 on consecutive cycles; out_last on the 6th element; done one cycle later; exactly 2 words accepted.
REQ-036 FP16, count=3, words 0xC0003C00 and 0x12344000, out_ready toggling 1/0 -> elements 0x00003C00, 0x0000C000, 0x00004000; each held stable through stall cycles; upper lane 0x1234 discarded.
REQ-037 FP32, count=2, in_valid constantly high, out_ready=1 -> one word per cycle; 2 elements on back-to-back cycles; in_ready low after the second word.
REQ-038 cfg_prec=11 -> err pulse, cfg_ready stays 1, in_ready stays 0; cfg_count=0 with INT8 -> done pulse, no in_ready.
REQ-039 rst asserted after 2 of 4 INT8 elements -> next cycle out_valid=0 and IDLE; a new FP32 job with count=1 then completes correctly.

Source files
------------

// File: rtl/mp_operand_unpack.sv
// Unpacks 32-bit words holding 4 x INT8, 2 x FP16 or 1 x FP32 into one
// 32-bit element per cycle, with a job configured by precision and element count.
module mp_operand_unpack #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [1:0]       cfg_prec,
  input  logic [CNT_W-1:0] cfg_count,
  output logic             cfg_ready,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [1:0]       out_prec,
  output logic             out_last,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  localparam logic [1:0]       PREC_INT8 = 2'b00;
  localparam logic [1:0]       PREC_FP16 = 2'b01;
  localparam logic [1:0]       PREC_ILL  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  function automatic logic [1:0] last_lane(input logic [1:0] prec);
    case (prec)
      PREC_INT8: last_lane = 2'd3;
      PREC_FP16: last_lane = 2'd1;
      default:   last_lane = 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  prec,
                                               input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lane[0] ? word[31:16] : word[15:0];
    case (prec)
      PREC_INT8: lane_extract = {{24{b[7]}}, b};
      PREC_FP16: lane_extract = {16'h0000, h};
      default:   lane_extract = word;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [31:0]      buf_q, buf_d;
  logic [1:0]       lane_q, lane_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       prec_q, prec_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             at_last_lane;
  logic             accept;
  logic             handshake;
  logic [CNT_W-1:0] cnt_rem;

  assign at_last_lane = (lane_q == last_lane(prec_q));
  assign out_valid    = (state_q == S_EMIT);
  assign cfg_ready    = (state_q == S_IDLE) && !rst;
  assign out_data     = out_data_q;
  assign out_prec     = prec_q;
  assign out_last     = out_last_q;
  assign done         = done_q;
  assign err          = err_q;
  assign accept       = in_valid && in_ready;
  assign handshake    = out_valid && out_ready;
  assign cnt_rem      = (cnt_q == CNT_ZERO) ? CNT_ZERO : (cnt_q - CNT_ONE);

  // Refill may overlap the last lane's handshake only when another element follows.
  always_comb begin
    in_ready = 1'b0;
    if (rst) begin
      in_ready = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: in_ready = 1'b1;
        S_EMIT:  in_ready = at_last_lane && (cnt_q != CNT_ONE) && out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  // Next-state and next-output computation for the unpack FSM.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    lane_d     = lane_q;
    cnt_d      = cnt_q;
    prec_d     = prec_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          if (cfg_prec == PREC_ILL) begin
            err_d = 1'b1;
          end else if (cfg_count == CNT_ZERO) begin
            done_d = 1'b1;
          end else begin
            prec_d  = cfg_prec;
            cnt_d   = cfg_count;
            lane_d  = 2'd0;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (accept) begin
          buf_d      = in_data;
          lane_d     = 2'd0;
          out_data_d = lane_extract(in_data, prec_q, 2'd0);
          out_last_d = (cnt_q == CNT_ONE);
          state_d    = S_EMIT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EMIT: begin
        if (handshake) begin
          cnt_d = cnt_rem;
          if (cnt_q == CNT_ONE) begin
            buf_d      = 32'h0000_0000;
            lane_d     = 2'd0;
            out_data_d = 32'h0000_0000;
            out_last_d = 1'b0;
            done_d     = 1'b1;
            state_d    = S_IDLE;
          end else if (at_last_lane) begin
            lane_d = 2'd0;
            if (accept) begin
              buf_d      = in_data;
              out_data_d = lane_extract(in_data, prec_q, 2'd0);
              out_last_d = (cnt_rem == CNT_ONE);
            end else begin
              out_last_d = 1'b0;
              state_d    = S_FETCH;
            end
          end else begin
            lane_d     = lane_q + 2'd1;
            out_data_d = lane_extract(buf_q, prec_q, lane_q + 2'd1);
            out_last_d = (cnt_rem == CNT_ONE);
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      buf_q      <= 32'h0000_0000;
      lane_q     <= 2'd0;
      cnt_q      <= CNT_ZERO;
      prec_q     <= 2'b00;
      out_data_q <= 32'h0000_0000;
      out_last_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      lane_q     <= lane_d;
      cnt_q      <= cnt_d;
      prec_q     <= prec_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_mp_operand_unpack.sv
// Self-checking bench for mp_operand_unpack: directed jobs plus randomized jobs
// checked against a list-based element model.
module tb_mp_operand_unpack;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic [1:0]       cfg_prec;
  logic [CNT_W-1:0] cfg_count;
  logic             cfg_ready;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [1:0]       out_prec;
  logic             out_last;
  logic             done;
  logic             err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] words_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] override_q[$];

  mp_operand_unpack #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_prec(cfg_prec), .cfg_count(cfg_count), .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_prec(out_prec), .out_last(out_last), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  function automatic int lanes_of(input logic [1:0] p);
    if (p == 2'd0) return 4;
    else if (p == 2'd1) return 2;
    else return 1;
  endfunction

  // Element value from the packing rules: LSB lane first, INT8 signed, FP16 unsigned.
  function automatic logic [31:0] ref_elem(input logic [31:0] w, input logic [1:0] p, input int lane);
    longint unsigned uw;
    longint v;
    uw = 64'(w);
    if (p == 2'd0) begin
      v = longint'((uw >> (8 * lane)) % 256);
      if (v >= 128) v = v - 256;
      return 32'(v);
    end else if (p == 2'd1) begin
      return 32'((uw >> (16 * lane)) % 65536);
    end else begin
      return w;
    end
  endfunction

  task automatic fill_random(input logic [1:0] p, input int count);
    int n;
    n = (count + lanes_of(p) - 1) / lanes_of(p);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back($urandom);
  endtask

  task automatic run_job(input string tag, input logic [1:0] p, input int count,
                         input int in_mode, input int out_mode, input bit check_burst);
    int eidx, widx, cyc, nwords, first_cyc, last_cyc;
    bit fin, got_done, prev_acc, toggle;
    eidx = 0; widx = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
    fin = 1'b0; got_done = 1'b0; prev_acc = 1'b0; toggle = 1'b1;
    nwords = (count + lanes_of(p) - 1) / lanes_of(p);
    exp_q.delete();
    if (override_q.size() > 0) begin
      exp_q = override_q;
      override_q.delete();
    end else begin
      for (int i = 0; i < count; i++)
        exp_q.push_back(ref_elem(words_q[i / lanes_of(p)], p, i % lanes_of(p)));
    end
    @(negedge clk);
    cfg_valid = 1'b1; cfg_prec = p; cfg_count = CNT_W'(count);
    in_valid = 1'b0; out_ready = 1'b0;
    #1 check({tag, " cfg_ready"}, 32'(cfg_ready), 32'd1);
    while (!got_done && cyc < 8 * count + 64) begin
      @(negedge clk);
      cyc++;
      if (!fin) begin
        cfg_valid = 1'($urandom_range(0, 1));
        cfg_prec  = 2'($urandom);
        cfg_count = CNT_W'($urandom);
      end else begin
        cfg_valid = 1'b0;
      end
      in_valid = (in_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      in_data  = (widx < nwords) ? words_q[widx] : $urandom;
      if (out_mode == 0) out_ready = 1'b1;
      else if (out_mode == 1) begin out_ready = toggle; toggle = !toggle; end
      else out_ready = 1'($urandom_range(0, 1));
      #1;
      if (fin) begin
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " idle cfg_ready"}, 32'(cfg_ready), 32'd1);
        got_done = 1'b1;
      end else begin
        check({tag, " no early done"}, 32'(done), 32'd0);
        if (prev_acc) check({tag, " lane0 latency"}, 32'(out_valid), 32'd1);
        if (out_valid) begin
          if (eidx < count) begin
            check({tag, " data"}, out_data, exp_q[eidx]);
            check({tag, " last"}, 32'(out_last), 32'(eidx == count - 1));
            check({tag, " prec"}, 32'(out_prec), 32'(p));
            if (out_ready) begin
              if (first_cyc < 0) first_cyc = cyc;
              if (eidx == count - 1) begin fin = 1'b1; last_cyc = cyc; end
              eidx++;
            end
          end else begin
            check({tag, " extra element"}, 32'(out_valid), 32'd0);
          end
        end
        prev_acc = in_valid && in_ready;
        if (prev_acc) widx++;
      end
    end
    check({tag, " completed in time"}, 32'(got_done), 32'd1);
    check({tag, " words accepted"}, 32'(widx), 32'(nwords));
    if (check_burst) check({tag, " no bubbles"}, 32'(last_cyc - first_cyc), 32'(count - 1));
    cfg_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic cfg_only(input string tag, input logic [1:0] p, input int count,
                          input bit exp_err, input bit exp_done);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_prec = p; cfg_count = CNT_W'(count);
    in_valid = 1'b1; in_data = $urandom; out_ready = 1'b1;
    #1 check({tag, " cfg_ready"}, 32'(cfg_ready), 32'd1);
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    cfg_valid = 1'b0;
    #1 check({tag, " err"}, 32'(err), 32'(exp_err));
    check({tag, " done"}, 32'(done), 32'(exp_done));
    check({tag, " cfg_ready after"}, 32'(cfg_ready), 32'd1);
    check({tag, " in_ready after"}, 32'(in_ready), 32'd0);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 check({tag, " err one pulse"}, 32'(err), 32'd0);
    check({tag, " done one pulse"}, 32'(done), 32'd0);
    check({tag, " still idle"}, 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    int hs;
    int cyc;
    rst = 1'b1; cfg_valid = 1'b0; cfg_prec = 2'b00; cfg_count = '0;
    in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset cfg_ready", 32'(cfg_ready), 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset out_prec", 32'(out_prec), 32'd0);
    check("reset out_last", 32'(out_last), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst = 1'b0;
    #1 check("cfg_ready after reset", 32'(cfg_ready), 32'd1);

    words_q    = '{32'h80FF7F01, 32'h00000302};
    override_q = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80, 32'h00000002, 32'h00000003};
    run_job("int8_dir", 2'd0, 6, 0, 0, 1'b1);

    words_q    = '{32'hC0003C00, 32'h12344000};
    override_q = '{32'h00003C00, 32'h0000C000, 32'h00004000};
    run_job("fp16_dir", 2'd1, 3, 0, 1, 1'b0);

    fill_random(2'd2, 2);
    run_job("fp32_dir", 2'd2, 2, 0, 0, 1'b1);

    cfg_only("illegal", 2'b11, 5, 1'b1, 1'b0);
    cfg_only("illegal_cnt0", 2'b11, 0, 1'b1, 1'b0);
    cfg_only("int8_cnt0", 2'b00, 0, 1'b0, 1'b1);
    cfg_only("fp16_cnt0", 2'b01, 0, 1'b0, 1'b1);

    // Abort an INT8 job after two of four elements.
    @(negedge clk);
    cfg_valid = 1'b1; cfg_prec = 2'b00; cfg_count = CNT_W'(4);
    @(negedge clk);
    cfg_valid = 1'b0; in_valid = 1'b1; in_data = 32'h44332211; out_ready = 1'b1;
    hs = 0; cyc = 0;
    #1;
    while (hs < 2 && cyc < 20) begin
      if (out_valid && out_ready) hs++;
      if (hs < 2) begin
        @(negedge clk);
        #1;
      end
      cyc++;
    end
    check("abort reached 2 elements", 32'(hs), 32'd2);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1 check("abort cfg_ready in rst", 32'(cfg_ready), 32'd0);
    check("abort in_ready in rst", 32'(in_ready), 32'd0);
    @(negedge clk);
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort out_data", out_data, 32'd0);
    check("abort out_prec", 32'(out_prec), 32'd0);
    check("abort out_last", 32'(out_last), 32'd0);
    check("abort done", 32'(done), 32'd0);
    rst = 1'b0;
    #1 check("abort cfg_ready released", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    #1 check("abort no done", 32'(done), 32'd0);

    words_q = '{32'hDEADBEEF};
    run_job("fp32_after_abort", 2'd2, 1, 0, 0, 1'b1);

    for (int j = 0; j < 25; j++) begin
      logic [1:0] p;
      int cnt;
      p   = 2'($urandom_range(0, 2));
      cnt = $urandom_range(1, 12);
      fill_random(p, cnt);
      run_job($sformatf("rand%0d", j), p, cnt, $urandom_range(0, 1) * 2,
              $urandom_range(0, 2), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
